// File: rtl/text_sequencer.sv
// Frame-rate banner sequencer: scrolls, holds, blinks and blanks each text
// overlay in turn, and gates the selected overlay bit into the pixel mux.
module text_sequencer #(
    parameter int NUM_MSGS     = 4,
    parameter int GAP_FRAMES   = 30,
    parameter int SHOW_FRAMES  = 120,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_HALF   = 8,
    parameter int START_COL    = 80,
    parameter int HOME_COL     = 18,
    parameter int SCROLL_STEP  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                hold,
    input  logic                skip,
    input  logic [NUM_MSGS-1:0] text_active,
    output logic                overlay_active,
    output logic [1:0]          msg_sel,
    output logic [6:0]          col_offset,
    output logic [1:0]          phase
);

    typedef enum logic [1:0] {
        GAP       = 2'd0,
        SCROLL_IN = 2'd1,
        SHOW      = 2'd2,
        BLINK     = 2'd3
    } state_t;

    localparam logic [6:0] START      = 7'(START_COL);
    localparam logic [6:0] HOME       = 7'(HOME_COL);
    localparam logic [6:0] STEP       = 7'(SCROLL_STEP);
    localparam logic [7:0] SCROLL_LIM = 8'(HOME_COL + SCROLL_STEP);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] SHOW_LAST  = 8'(SHOW_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] BLINK_MASK = 8'(BLINK_HALF);
    localparam logic [1:0] LAST_MSG   = 2'(NUM_MSGS - 1);

    state_t     state;
    logic [7:0] frame_cnt;
    logic [3:0] text_pad;
    logic       visible;
    logic [1:0] msg_next;

    assign phase = state;

    always_comb begin
        text_pad = '0;
        text_pad[NUM_MSGS-1:0] = text_active;
        visible = (state == SCROLL_IN) || (state == SHOW) ||
                  ((state == BLINK) && ((frame_cnt & BLINK_MASK) == 8'd0));
        msg_next = (msg_sel == LAST_MSG) ? 2'd0 : msg_sel + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= GAP;
            frame_cnt      <= 8'd0;
            col_offset     <= START;
            msg_sel        <= 2'd0;
            overlay_active <= 1'b0;
        end else begin
            // Gating runs every cycle so a held frame stays on screen.
            overlay_active <= visible & text_pad[msg_sel];
            if (skip) begin
                state      <= GAP;
                frame_cnt  <= 8'd0;
                col_offset <= START;
                msg_sel    <= msg_next;
            end else if (frame_tick && !hold) begin
                unique case (state)
                    GAP: begin
                        col_offset <= START;
                        if (frame_cnt == GAP_LAST) begin
                            state     <= SCROLL_IN;
                            frame_cnt <= 8'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    SCROLL_IN: begin
                        // Snap to home instead of stepping past it.
                        if ({1'b0, col_offset} <= SCROLL_LIM) begin
                            col_offset <= HOME;
                            state      <= SHOW;
                            frame_cnt  <= 8'd0;
                        end else begin
                            col_offset <= col_offset - STEP;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end
                    end
                    SHOW: begin
                        if (frame_cnt == SHOW_LAST) begin
                            state     <= BLINK;
                            frame_cnt <= 8'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    BLINK: begin
                        if (frame_cnt == BLINK_LAST) begin
                            state      <= GAP;
                            frame_cnt  <= 8'd0;
                            col_offset <= START;
                            msg_sel    <= msg_next;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_text_sequencer.sv
// Scoreboard bench for text_sequencer: a per-position table of expected
// outputs is queued per frame tick and compared once the DUT has updated.
module tb_text_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       hold = 1'b0;
    logic       skip = 1'b0;
    logic [2:0] text_active = 3'b111;
    logic       overlay_active;
    logic [1:0] msg_sel;
    logic [6:0] col_offset;
    logic [1:0] phase;

    int tests = 0;
    int fails = 0;

    text_sequencer #(
        .NUM_MSGS(3), .GAP_FRAMES(2), .SHOW_FRAMES(3), .BLINK_FRAMES(4),
        .BLINK_HALF(2), .START_COL(24), .HOME_COL(18), .SCROLL_STEP(4)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .hold(hold),
        .skip(skip), .text_active(text_active),
        .overlay_active(overlay_active), .msg_sel(msg_sel),
        .col_offset(col_offset), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [6:0] col;
        logic [1:0] msg;
        logic       ovl;
    } exp_t;

    exp_t sb[$];

    // Expected outputs after k ticks since the start of a GAP (cycle = 11 ticks).
    logic [1:0] ph_tab  [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3};
    int         col_tab [11] = '{24, 24, 24, 20, 18, 18, 18, 18, 18, 18, 18};
    bit         vis_tab [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    int pos = 0;
    int msg = 0;

    task automatic do_tick(input bit held);
        exp_t e;
        exp_t got;
        if (!held) begin
            pos++;
            if (pos == 11) begin
                pos = 0;
                msg = (msg + 1) % 3;
            end
        end
        e.ph  = ph_tab[pos];
        e.col = 7'(col_tab[pos]);
        e.msg = 2'(msg);
        e.ovl = vis_tab[pos] & text_active[msg];
        sb.push_back(e);
        @(negedge clk);
        frame_tick = 1'b1;
        hold = held;
        @(negedge clk);
        frame_tick = 1'b0;
        got = sb.pop_front();
        tests += 3;
        if (phase !== got.ph) begin
            fails++;
            $display("FAIL tick_phase pos=%0d got=%0d want=%0d", pos, phase, got.ph);
        end
        if (col_offset !== got.col) begin
            fails++;
            $display("FAIL tick_col pos=%0d got=%0d want=%0d", pos, col_offset, got.col);
        end
        if (msg_sel !== got.msg) begin
            fails++;
            $display("FAIL tick_msg pos=%0d got=%0d want=%0d", pos, msg_sel, got.msg);
        end
        repeat (14) @(negedge clk);
        tests++;
        if (overlay_active !== got.ovl) begin
            fails++;
            $display("FAIL tick_overlay pos=%0d got=%0b want=%0b",
                     pos, overlay_active, got.ovl);
        end
    endtask

    task automatic advance_to(input int p, input int m);
        int n = 0;
        while (!(pos == p && msg == m) && n < 40) begin
            do_tick(1'b0);
            n++;
        end
        tests++;
        if (!(pos == p && msg == m)) begin
            fails++;
            $display("FAIL advance_timeout pos=%0d msg=%0d want %0d/%0d", pos, msg, p, m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests += 4;
        if (phase !== 2'd0) begin
            fails++; $display("FAIL reset_phase got=%0d want=0", phase);
        end
        if (msg_sel !== 2'd0) begin
            fails++; $display("FAIL reset_msg got=%0d want=0", msg_sel);
        end
        if (col_offset !== 7'd24) begin
            fails++; $display("FAIL reset_col got=%0d want=24", col_offset);
        end
        if (overlay_active !== 1'b0) begin
            fails++; $display("FAIL reset_overlay got=%0b want=0", overlay_active);
        end
        reset = 1'b0;
        pos = 0;
        msg = 0;
    endtask

    task automatic test_gap();
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (overlay_active !== 1'b0) begin
                fails++; $display("FAIL gap_overlay got=%0b want=0", overlay_active);
            end
        end
        do_tick(1'b0);
        do_tick(1'b0);
    endtask

    task automatic test_scroll_show();
        do_tick(1'b0);
        do_tick(1'b0);
        @(negedge clk);
        text_active = 3'b110;
        #1;
        tests++;
        if (overlay_active !== 1'b1) begin
            fails++; $display("FAIL latency_early got=%0b want=1", overlay_active);
        end
        @(negedge clk);
        tests++;
        if (overlay_active !== 1'b0) begin
            fails++; $display("FAIL latency_fall got=%0b want=0", overlay_active);
        end
        text_active = 3'b001;
        @(negedge clk);
        tests++;
        if (overlay_active !== 1'b1) begin
            fails++; $display("FAIL latency_rise got=%0b want=1", overlay_active);
        end
        text_active = 3'b111;
        @(negedge clk);
    endtask

    task automatic test_blink_wrap();
        advance_to(0, 1);
        advance_to(0, 0);
        tests++;
        if (msg_sel !== 2'd0) begin
            fails++; $display("FAIL wrap_msg got=%0d want=0", msg_sel);
        end
    endtask

    task automatic test_hold();
        advance_to(4, msg);
        text_active = 3'b000;
        do_tick(1'b1);
        do_tick(1'b1);
        text_active = 3'b111;
        do_tick(1'b1);
        do_tick(1'b1);
        do_tick(1'b1);
        @(negedge clk);
        hold = 1'b0;
        do_tick(1'b0);
        do_tick(1'b0);
        do_tick(1'b0);
    endtask

    task automatic test_skip();
        advance_to(2, msg);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            skip = 1'b1;
            frame_tick = (i == 0);
            hold = (i == 0);
            @(negedge clk);
            skip = 1'b0;
            frame_tick = 1'b0;
            hold = 1'b0;
            msg = (msg + 1) % 3;
            pos = 0;
            tests += 3;
            if (phase !== 2'd0) begin
                fails++; $display("FAIL skip_phase i=%0d got=%0d want=0", i, phase);
            end
            if (col_offset !== 7'd24) begin
                fails++; $display("FAIL skip_col i=%0d got=%0d want=24", i, col_offset);
            end
            if (msg_sel !== 2'(msg)) begin
                fails++; $display("FAIL skip_msg i=%0d got=%0d want=%0d", i, msg_sel, msg);
            end
        end
        do_tick(1'b0);
        do_tick(1'b0);
    endtask

    task automatic test_reset_mid();
        advance_to(8, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests += 4;
        if (phase !== 2'd0) begin
            fails++; $display("FAIL midreset_phase got=%0d want=0", phase);
        end
        if (msg_sel !== 2'd0) begin
            fails++; $display("FAIL midreset_msg got=%0d want=0", msg_sel);
        end
        if (col_offset !== 7'd24) begin
            fails++; $display("FAIL midreset_col got=%0d want=24", col_offset);
        end
        if (overlay_active !== 1'b0) begin
            fails++; $display("FAIL midreset_overlay got=%0b want=0", overlay_active);
        end
        @(negedge clk);
        reset = 1'b0;
        pos = 0;
        msg = 0;
        do_tick(1'b0);
        do_tick(1'b0);
        do_tick(1'b0);
    endtask

    initial begin
        test_reset();
        test_gap();
        test_scroll_show();
        test_blink_wrap();
        test_hold();
        test_skip();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
